// File: rtl/tone_dac_streamer_if.sv
// tone_dac_streamer_if: sine ROM read port and codec serial pins
interface tone_dac_streamer_if #(
  parameter int ROM_AW = 8,
  parameter int SAMPLE_W = 16
);
  logic [ROM_AW-1:0] rom_addr;
  logic rom_rden;
  logic [SAMPLE_W-1:0] rom_q;
  logic bclk;
  logic dac_lrclk;
  logic dac_data;
  modport master(output rom_addr, rom_rden, bclk, dac_lrclk, dac_data, input rom_q);
  modport slave(input rom_addr, rom_rden, bclk, dac_lrclk, dac_data, output rom_q);
endinterface

// File: rtl/tone_dac_streamer.sv
// tone_dac_streamer: multi-tone synthesiser with saturating stereo mix and DSP/I2S codec framer
module tone_dac_streamer #(
  parameter int NUM_TONES = 4,
  parameter int PHASE_W = 18,
  parameter int ROM_AW = 8,
  parameter int SAMPLE_W = 16,
  parameter int GAIN_W = 4,
  parameter int OUT_SHIFT = 2,
  parameter int SLOT_W = 16,
  parameter int BCLK_HALF = 16,
  parameter int MODE = 0
) (
  input logic clk,
  input logic reset,
  input logic enable,
  input logic [NUM_TONES*PHASE_W-1:0] inc,
  input logic [NUM_TONES*GAIN_W-1:0] gain,
  input logic [NUM_TONES-1:0] left_mask,
  input logic [NUM_TONES-1:0] right_mask,
  tone_dac_streamer_if.master bus,
  output logic sample_strobe,
  output logic clip
);
  localparam int BITS = 2 * SLOT_W;
  localparam int DW = $clog2(BCLK_HALF);
  localparam int BW = $clog2(BITS);
  localparam int TW = NUM_TONES > 1 ? $clog2(NUM_TONES) : 1;
  localparam int PW = SAMPLE_W + GAIN_W + 1;
  localparam int SW = PW + $clog2(NUM_TONES);
  localparam logic signed [SW-1:0] MAXV = SW'((1 << (SAMPLE_W - 1)) - 1);
  localparam logic signed [SW-1:0] MINV = ~MAXV;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, SAT} state_t;
  state_t state, state_nxt;
  logic [TW-1:0] t, t_nxt;
  logic [DW-1:0] div;
  logic [BW-1:0] bitc, bit_nxt;
  logic run, tc, fall, fs, lr_nxt, last;
  logic [BITS-1:0] sh, sh_nxt;
  logic [PHASE_W-1:0] acc [NUM_TONES];
  logic [PHASE_W-1:0] acc_nxt [NUM_TONES];
  logic [NUM_TONES*GAIN_W-1:0] gain_s;
  logic [NUM_TONES-1:0] lm_s, rm_s;
  logic signed [PW-1:0] prod;
  logic signed [SW-1:0] sum_l, sum_r, shl, shr;
  logic [SAMPLE_W-1:0] pend_l, pend_r, sat_l, sat_r;
  logic clamp_l, clamp_r;
  // bclk terminal count, frame start (first fall after enable or bit counter wrap) and next serial frame
  always_comb begin
    tc = enable && div == DW'(BCLK_HALF - 1);
    fall = tc && bus.bclk;
    last = bitc == BW'(BITS - 1);
    fs = fall && (!run || last);
    bit_nxt = (!run || last) ? '0 : bitc + 1'b1;
    lr_nxt = MODE != 0 ? bit_nxt >= BW'(SLOT_W) : bit_nxt == '0;
    sh_nxt = fs ? (BITS'(pend_l) << (BITS - SAMPLE_W)) | (BITS'(pend_r) << (SLOT_W - SAMPLE_W)) : sh << 1;
  end
  // divider, bit counter and serialiser; I2S emits the bit of the previous period
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      div <= '0;
      bitc <= '0;
      run <= 1'b0;
      sh <= '0;
      bus.bclk <= 1'b0;
      bus.dac_lrclk <= 1'b0;
      bus.dac_data <= 1'b0;
    end else begin
      div <= tc ? '0 : div + 1'b1;
      if (tc) bus.bclk <= !bus.bclk;
      if (fall) begin
        bitc <= bit_nxt;
        run <= 1'b1;
        sh <= sh_nxt;
        bus.dac_lrclk <= lr_nxt;
        bus.dac_data <= MODE != 0 ? sh[BITS-1] : sh_nxt[BITS-1];
      end
    end
  end
  // accumulators step once per frame start
  always_comb begin
    for (int i = 0; i < NUM_TONES; i++) acc_nxt[i] = acc[i] + (fs ? inc[i*PHASE_W +: PHASE_W] : '0);
  end
  // accumulator state, per-frame snapshot of gains and masks, frame strobe
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_TONES; i++) acc[i] <= reset ? '0 : acc_nxt[i];
    if (reset) begin
      gain_s <= '0;
      lm_s <= '0;
      rm_s <= '0;
    end else if (fs) begin
      gain_s <= gain;
      lm_s <= left_mask;
      rm_s <= right_mask;
    end
    sample_strobe <= !reset && fs;
  end
  // FSM state register
  always_ff @(posedge clk) begin
    state <= reset ? IDLE : state_nxt;
    t <= reset ? '0 : t_nxt;
  end
  // FSM sequencing: one ISSUE/CAPTURE pair per tone, then saturate
  always_comb begin
    state_nxt = state;
    t_nxt = t;
    case (state)
      IDLE: if (fs) begin
        state_nxt = ISSUE;
        t_nxt = '0;
      end
      ISSUE: state_nxt = CAPTURE;
      CAPTURE: begin
        state_nxt = t == TW'(NUM_TONES - 1) ? SAT : ISSUE;
        t_nxt = t == TW'(NUM_TONES - 1) ? '0 : t + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // scaled tone sample and saturated channel results
  always_comb begin
    prod = PW'($signed(bus.rom_q)) * PW'($signed({1'b0, gain_s[t*GAIN_W +: GAIN_W]}));
    shl = sum_l >>> OUT_SHIFT;
    shr = sum_r >>> OUT_SHIFT;
    clamp_l = shl > MAXV || shl < MINV;
    clamp_r = shr > MAXV || shr < MINV;
    sat_l = shl > MAXV ? MAXV[SAMPLE_W-1:0] : shl < MINV ? MINV[SAMPLE_W-1:0] : shl[SAMPLE_W-1:0];
    sat_r = shr > MAXV ? MAXV[SAMPLE_W-1:0] : shr < MINV ? MINV[SAMPLE_W-1:0] : shr[SAMPLE_W-1:0];
  end
  // ROM port, channel accumulation and pending words; disable discards pending samples
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rom_rden <= 1'b0;
      bus.rom_addr <= '0;
      sum_l <= '0;
      sum_r <= '0;
      pend_l <= '0;
      pend_r <= '0;
      clip <= 1'b0;
    end else begin
      bus.rom_rden <= enable && state_nxt == ISSUE;
      bus.rom_addr <= state_nxt == ISSUE ? acc_nxt[t_nxt][PHASE_W-1 -: ROM_AW] : '0;
      if (state == ISSUE && t == '0) begin
        sum_l <= '0;
        sum_r <= '0;
      end
      if (state == CAPTURE && lm_s[t]) sum_l <= sum_l + SW'(prod);
      if (state == CAPTURE && rm_s[t]) sum_r <= sum_r + SW'(prod);
      if (state == SAT) clip <= clip | clamp_l | clamp_r;
      pend_l <= !enable ? '0 : state == SAT ? sat_l : pend_l;
      pend_r <= !enable ? '0 : state == SAT ? sat_r : pend_r;
    end
  end
endmodule

// File: tb/tb_tone_dac_streamer.sv
// tb_tone_dac_streamer: directed checks of tone synthesis, saturation, wrap and DSP/I2S framing
module tb_tone_dac_streamer;
  localparam int NT = 4;
  localparam int PW = 18;
  localparam int GW = 4;
  localparam int SLOT = 16;
  localparam int BH = 16;
  localparam int FRAME = 4 * BH * SLOT;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [NT*PW-1:0] inc = '0;
  logic [NT*GW-1:0] gain = '0;
  logic [NT-1:0] lm = '0;
  logic [NT-1:0] rm = '0;
  logic strobe0, strobe1, clip0, clip1;
  int checks = 0;
  int errors = 0;
  int rom_mode = 0;
  logic [15:0] rom_const = '0;
  tone_dac_streamer_if #(.ROM_AW(8), .SAMPLE_W(16)) bus0 ();
  tone_dac_streamer_if #(.ROM_AW(8), .SAMPLE_W(16)) bus1 ();
  tone_dac_streamer #(.OUT_SHIFT(0), .MODE(0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .inc(inc), .gain(gain),
    .left_mask(lm), .right_mask(rm), .bus(bus0), .sample_strobe(strobe0), .clip(clip0)
  );
  tone_dac_streamer #(.OUT_SHIFT(0), .MODE(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .inc(inc), .gain(gain),
    .left_mask(lm), .right_mask(rm), .bus(bus1), .sample_strobe(strobe1), .clip(clip1)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] rom_f(input logic [7:0] a);
    return rom_mode == 0 ? {a, 6'b0} : rom_mode == 1 ? rom_const : (a == 8'd0 ? 16'hA5C3 : 16'h3C5A);
  endfunction
  // sine ROM stand-ins with one-cycle read latency
  always @(posedge clk) begin
    if (bus0.rom_rden) bus0.rom_q <= rom_f(bus0.rom_addr);
    if (bus1.rom_rden) bus1.rom_q <= rom_f(bus1.rom_addr);
  end
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic wait_strobe(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!strobe0 && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    ok = strobe0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL strobe_timeout got=0 exp=1");
    end
  endtask
  task automatic capture(output logic [31:0] d0, output logic [31:0] l0, output logic [31:0] d1, output logic [31:0] l1);
    bit ok;
    wait_strobe(ok);
    for (int p = 0; p < 2 * SLOT; p++) begin
      if (p > 0) repeat (2 * BH) @(negedge clk);
      d0[31-p] = bus0.dac_data;
      l0[31-p] = bus0.dac_lrclk;
      d1[31-p] = bus1.dac_data;
      l1[31-p] = bus1.dac_lrclk;
    end
  endtask
  task automatic test_reset();
    bit bad = 0;
    do_reset();
    repeat (1000) begin
      @(negedge clk);
      if ({bus0.bclk, bus0.dac_lrclk, bus0.dac_data, bus0.rom_rden, clip0,
           bus1.bclk, bus1.dac_lrclk, bus1.dac_data, bus1.rom_rden, clip1} !== '0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL idle_outputs got=nonzero exp=all zero");
    end
    checks++;
    if ({bus0.rom_addr, strobe0, strobe1} !== '0) begin
      errors++;
      $display("FAIL idle_addr_strobe got=%h exp=0", {bus0.rom_addr, strobe0, strobe1});
    end
  endtask
  task automatic test_single_tone();
    logic [31:0] d0, l0, d1, l1;
    bit ok;
    int n;
    do_reset();
    rom_mode = 0;
    inc = '0;
    inc[0 +: PW] = 18'd1024;
    gain = 16'h0001;
    lm = 4'b0001;
    rm = 4'b0000;
    enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      capture(d0, l0, d1, l1);
      checks++;
      if (d0[31:16] !== 16'((k - 1) * 64)) begin
        errors++;
        $display("FAIL tone_left_f%0d got=%h exp=%h", k, d0[31:16], 16'((k - 1) * 64));
      end
      checks++;
      if (d0[15:0] !== 16'h0) begin
        errors++;
        $display("FAIL tone_right_f%0d got=%h exp=0000", k, d0[15:0]);
      end
    end
    wait_strobe(ok);
    @(negedge clk);
    checks++;
    if (strobe0 !== 1'b0) begin
      errors++;
      $display("FAIL strobe_width got=%b exp=0", strobe0);
    end
    n = 1;
    while (!strobe0 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != FRAME) begin
      errors++;
      $display("FAIL strobe_period got=%0d exp=%0d", n, FRAME);
    end
  endtask
  task automatic test_saturation();
    logic [31:0] d0, l0, d1, l1;
    do_reset();
    rom_mode = 1;
    rom_const = 16'h7FFF;
    inc = {4{18'd1024}};
    gain = 16'hFFFF;
    lm = 4'hF;
    rm = 4'hF;
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if ({clip0, clip1} !== 2'b00) begin
      errors++;
      $display("FAIL clip_initial got=%b exp=00", {clip0, clip1});
    end
    capture(d0, l0, d1, l1);
    capture(d0, l0, d1, l1);
    checks++;
    if (d0 !== 32'h7FFF_7FFF) begin
      errors++;
      $display("FAIL sat_pos got=%h exp=7fff7fff", d0);
    end
    checks++;
    if ({clip0, clip1} !== 2'b11) begin
      errors++;
      $display("FAIL clip_set got=%b exp=11", {clip0, clip1});
    end
    rom_const = 16'h8000;
    capture(d0, l0, d1, l1);
    capture(d0, l0, d1, l1);
    checks++;
    if (d0 !== 32'h8000_8000) begin
      errors++;
      $display("FAIL sat_neg got=%h exp=80008000", d0);
    end
    checks++;
    if (d1 !== {1'b1, 16'h8000, 15'h4000}) begin
      errors++;
      $display("FAIL i2s_prev_lsb got=%h exp=%h", d1, {1'b1, 16'h8000, 15'h4000});
    end
    checks++;
    if ({clip0, clip1} !== 2'b11) begin
      errors++;
      $display("FAIL clip_sticky got=%b exp=11", {clip0, clip1});
    end
  endtask
  task automatic test_wrap();
    logic [31:0] d0, l0, d1, l1;
    bit ok;
    do_reset();
    rom_mode = 0;
    inc = '0;
    inc[0 +: PW] = 18'h3FC00;
    gain = 16'h0001;
    lm = 4'b0001;
    rm = 4'b0000;
    enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wait_strobe(ok);
      checks++;
      if ({bus0.rom_rden, bus0.rom_addr} !== {1'b1, 8'(256 - k)}) begin
        errors++;
        $display("FAIL wrap_addr_f%0d got=%h exp=%h", k, {bus0.rom_rden, bus0.rom_addr}, {1'b1, 8'(256 - k)});
      end
    end
    capture(d0, l0, d1, l1);
    checks++;
    if (d0 !== 32'h3F00_0000) begin
      errors++;
      $display("FAIL wrap_word got=%h exp=3f000000", d0);
    end
  endtask
  task automatic test_framing();
    logic [31:0] d0, l0, d1, l1;
    do_reset();
    rom_mode = 2;
    inc = '0;
    inc[PW +: PW] = 18'd1024;
    gain = 16'h0011;
    lm = 4'b0001;
    rm = 4'b0010;
    enable = 1'b1;
    capture(d0, l0, d1, l1);
    checks++;
    if ({d0, d1} !== 64'h0) begin
      errors++;
      $display("FAIL frame1_zero got=%h exp=0", {d0, d1});
    end
    checks++;
    if (l0 !== 32'h8000_0000) begin
      errors++;
      $display("FAIL dsp_lrclk_f1 got=%h exp=80000000", l0);
    end
    checks++;
    if (l1 !== 32'h0000_FFFF) begin
      errors++;
      $display("FAIL i2s_lrclk_f1 got=%h exp=0000ffff", l1);
    end
    capture(d0, l0, d1, l1);
    checks++;
    if (d0 !== 32'hA5C3_3C5A) begin
      errors++;
      $display("FAIL dsp_data got=%h exp=a5c33c5a", d0);
    end
    checks++;
    if (d1 !== {1'b0, 16'hA5C3, 15'h1E2D}) begin
      errors++;
      $display("FAIL i2s_data got=%h exp=%h", d1, {1'b0, 16'hA5C3, 15'h1E2D});
    end
    checks++;
    if ({l0, l1} !== {32'h8000_0000, 32'h0000_FFFF}) begin
      errors++;
      $display("FAIL lrclk_f2 got=%h exp=800000000000ffff", {l0, l1});
    end
    checks++;
    if (clip0 !== 1'b0) begin
      errors++;
      $display("FAIL framing_clip got=%b exp=0", clip0);
    end
  endtask
  task automatic test_midframe_reset();
    logic [31:0] d0, l0, d1, l1;
    bit ok;
    wait_strobe(ok);
    repeat (9 * 2 * BH) @(negedge clk);
    checks++;
    if ({bus0.dac_data, bus0.dac_lrclk} !== 2'b10) begin
      errors++;
      $display("FAIL period9_pins got=%b exp=10", {bus0.dac_data, bus0.dac_lrclk});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus0.bclk, bus0.dac_lrclk, bus0.dac_data, bus0.rom_rden, bus0.rom_addr, strobe0, clip0,
         bus1.bclk, bus1.dac_lrclk, bus1.dac_data, bus1.rom_rden, strobe1, clip1} !== '0) begin
      errors++;
      $display("FAIL midframe_reset got=nonzero exp=all zero");
    end
    reset = 1'b0;
    capture(d0, l0, d1, l1);
    checks++;
    if ({d0, d1} !== 64'h0) begin
      errors++;
      $display("FAIL restart_zero got=%h exp=0", {d0, d1});
    end
    capture(d0, l0, d1, l1);
    checks++;
    if (d0 !== 32'hA5C3_3C5A) begin
      errors++;
      $display("FAIL restart_data got=%h exp=a5c33c5a", d0);
    end
  endtask
  task automatic test_disable();
    logic [31:0] d0, l0, d1, l1;
    bit ok;
    wait_strobe(ok);
    repeat (9 * 2 * BH) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus0.bclk, bus0.dac_lrclk, bus0.dac_data, bus0.rom_rden,
         bus1.bclk, bus1.dac_lrclk, bus1.dac_data, bus1.rom_rden} !== '0) begin
      errors++;
      $display("FAIL disable_pins got=nonzero exp=all zero");
    end
    repeat (5) @(negedge clk);
    enable = 1'b1;
    capture(d0, l0, d1, l1);
    checks++;
    if ({d0, d1} !== 64'h0) begin
      errors++;
      $display("FAIL reenable_zero got=%h exp=0", {d0, d1});
    end
    capture(d0, l0, d1, l1);
    checks++;
    if (d0 !== 32'hA5C3_3C5A) begin
      errors++;
      $display("FAIL reenable_data got=%h exp=a5c33c5a", d0);
    end
  endtask
  initial begin
    test_reset();
    test_single_tone();
    test_saturation();
    test_wrap();
    test_framing();
    test_midframe_reset();
    test_disable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
